dcache_flush_unit: RTL and testbench

Write-back data-cache flush sequencer that executes the `flush_dcache` request issued by the pipeline flush controller for `fence` and `fence.i`. It walks every set/way of the cache metadata, writes back each dirty line, and clears it. It then returns a single-cycle acknowledge, which the controller consumes to release its fence halt. The block sits between the flush controller and the cache's metadata array and write-back port.

---
 rtl/dcache_flush_unit_pkg.sv | 6 +
 rtl/dcache_flush_unit.sv | 118 +++++++++++
 tb/tb_dcache_flush_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_flush_unit_pkg.sv
// dcache_flush_unit_pkg: shared data-cache geometry constants.
package dcache_flush_unit_pkg;
   localparam int unsigned DCACHE_NUM_SETS  = 256;
   localparam int unsigned DCACHE_NUM_WAYS  = 8;
   localparam int unsigned DCACHE_TAG_WIDTH = 44;
endpackage

// File: rtl/dcache_flush_unit.sv
// dcache_flush_unit: walks every set/way, writes back dirty lines, clears them, then acks once.
// DCACHE_FLUSH_KEEP_VALID_EN: clean-only mode, lines stay valid and only dirty lines are rewritten.
module dcache_flush_unit
   import dcache_flush_unit_pkg::*;
#(
   parameter int unsigned NUM_SETS  = DCACHE_NUM_SETS,
   parameter int unsigned NUM_WAYS  = DCACHE_NUM_WAYS,
   parameter int unsigned TAG_WIDTH = DCACHE_TAG_WIDTH,
   localparam int unsigned SW = $clog2(NUM_SETS),
   localparam int unsigned WW = $clog2(NUM_WAYS)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   output logic                 flush_ack_o,
   output logic                 busy_o,
   output logic                 meta_req_o,
   input  logic                 meta_gnt_i,
   output logic                 meta_we_o,
   output logic [SW-1:0]        meta_set_o,
   output logic [WW-1:0]        meta_way_o,
   output logic                 meta_wvalid_o,
   input  logic                 meta_rvalid_i,
   input  logic                 meta_valid_i,
   input  logic                 meta_dirty_i,
   input  logic [TAG_WIDTH-1:0] meta_tag_i,
   output logic                 wb_req_o,
   input  logic                 wb_gnt_i,
   output logic [TAG_WIDTH-1:0] wb_tag_o,
   output logic [SW-1:0]        wb_set_o,
   input  logic                 wb_done_i
);
`ifdef DCACHE_FLUSH_KEEP_VALID_EN
   localparam logic KEEP_VALID = 1'b1;
`else
   localparam logic KEEP_VALID = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, READ, WAIT_META, WRITEBACK, WAIT_WB, CLEAR, NEXT, DONE} state_e;

   state_e               state_q, state_d;
   logic [SW-1:0]        set_q, set_d;
   logic [WW-1:0]        way_q, way_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;
   logic                 meta_req_q, meta_we_q, meta_wvalid_q, wb_req_q, busy_q, ack_q;

   always_comb begin
      state_d = state_q;
      set_d   = set_q;
      way_d   = way_q;
      tag_d   = tag_q;
      case (state_q)
         IDLE: if (flush_i) begin
            state_d = READ;
            set_d   = '0;
            way_d   = '0;
         end
         READ:      state_d = meta_gnt_i ? WAIT_META : READ;
         WAIT_META: if (meta_rvalid_i) begin
            if (meta_valid_i && meta_dirty_i) begin
               tag_d   = meta_tag_i;
               state_d = WRITEBACK;
            end else begin
               state_d = (meta_valid_i && !KEEP_VALID) ? CLEAR : NEXT;
            end
         end
         WRITEBACK: state_d = wb_gnt_i ? WAIT_WB : WRITEBACK;
         WAIT_WB:   state_d = wb_done_i ? CLEAR : WAIT_WB;
         CLEAR:     state_d = meta_gnt_i ? NEXT : CLEAR;
         NEXT: if (&set_q && &way_q) begin
            state_d = DONE;
         end else begin
            way_d   = way_q + WW'(1);
            set_d   = &way_q ? set_q + SW'(1) : set_q;
            state_d = READ;
         end
         default:   state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         set_q         <= '0;
         way_q         <= '0;
         tag_q         <= '0;
         meta_req_q    <= 1'b0;
         meta_we_q     <= 1'b0;
         meta_wvalid_q <= 1'b0;
         wb_req_q      <= 1'b0;
         busy_q        <= 1'b0;
         ack_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         set_q         <= set_d;
         way_q         <= way_d;
         tag_q         <= tag_d;
         meta_req_q    <= state_d == READ || state_d == CLEAR;
         meta_we_q     <= state_d == CLEAR;
         meta_wvalid_q <= KEEP_VALID && state_d == CLEAR;
         wb_req_q      <= state_d == WRITEBACK;
         busy_q        <= state_d != IDLE;
         ack_q         <= state_d == DONE;
      end
   end

   assign flush_ack_o   = ack_q;
   assign busy_o        = busy_q;
   assign meta_req_o    = meta_req_q;
   assign meta_we_o     = meta_we_q;
   assign meta_wvalid_o = meta_wvalid_q;
   assign meta_set_o    = set_q;
   assign meta_way_o    = way_q;
   assign wb_req_o      = wb_req_q;
   assign wb_tag_o      = tag_q;
   assign wb_set_o      = set_q;
endmodule

// File: tb/tb_dcache_flush_unit.sv
// tb_dcache_flush_unit: table-driven flush vectors against a metadata/write-back responder and event scoreboard.
module tb_dcache_flush_unit;
   localparam int NS = 4, NW = 2, N = NS * NW, TW = 44;
`ifdef DCACHE_FLUSH_KEEP_VALID_EN
   localparam bit KEEP = 1'b1;
`else
   localparam bit KEEP = 1'b0;
`endif
   localparam int K_WB = 1, K_WR = 2;

   logic          clk_i = 0, rst_ni = 0, flush_i = 0;
   logic          flush_ack_o, busy_o, meta_req_o, meta_we_o, meta_wvalid_o, wb_req_o;
   logic          meta_gnt_i = 0, meta_rvalid_i = 0, meta_valid_i = 0, meta_dirty_i = 0;
   logic          wb_gnt_i = 0, wb_done_i = 0;
   logic [1:0]    meta_set_o, wb_set_o;
   logic [0:0]    meta_way_o;
   logic [TW-1:0] meta_tag_i = '0, wb_tag_o;

   dcache_flush_unit #(.NUM_SETS(NS), .NUM_WAYS(NW), .TAG_WIDTH(TW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .flush_ack_o(flush_ack_o), .busy_o(busy_o),
      .meta_req_o(meta_req_o), .meta_gnt_i(meta_gnt_i), .meta_we_o(meta_we_o), .meta_set_o(meta_set_o),
      .meta_way_o(meta_way_o), .meta_wvalid_o(meta_wvalid_o), .meta_rvalid_i(meta_rvalid_i),
      .meta_valid_i(meta_valid_i), .meta_dirty_i(meta_dirty_i), .meta_tag_i(meta_tag_i),
      .wb_req_o(wb_req_o), .wb_gnt_i(wb_gnt_i), .wb_tag_o(wb_tag_o), .wb_set_o(wb_set_o), .wb_done_i(wb_done_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int kind; int set; int way; logic [TW-1:0] tag; logic wv;
   } exp_t;
   typedef struct {
      int idx; bit v; bit d; logic [TW-1:0] tag; int lat; int stall; int ack; int nwb; int nwr;
   } vec_t;

   exp_t          sb[$];
   vec_t          vecs[6];
   bit            mv[N], md[N];
   logic [TW-1:0] mt[N];
   int            n_tests = 0, n_fail = 0;
   int            wb_seen, wr_seen, wb_lat, stall_left;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic load(input int idx, input bit v, input bit d, input logic [TW-1:0] tag);
      for (int i = 0; i < N; i++) begin
         mv[i] = 0; md[i] = 0; mt[i] = '0;
      end
      if (idx >= 0) begin
         mv[idx] = v; md[idx] = d; mt[idx] = tag;
      end
   endtask

   task automatic build_sb();
      sb.delete();
      for (int i = 0; i < N; i++) begin
         if (mv[i] && md[i]) begin
            sb.push_back('{K_WB, i / NW, i % NW, mt[i], 1'b0});
            sb.push_back('{K_WR, i / NW, i % NW, '0, KEEP});
         end else if (mv[i] && !KEEP) begin
            sb.push_back('{K_WR, i / NW, i % NW, '0, 1'b0});
         end
      end
   endtask

   task automatic run_flush(input int exp_ack, input int off, input bit hold);
      int cyc = 0;
      bit got = 0;
      flush_i = 1;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(posedge clk_i); cyc++;
         @(negedge clk_i);
         if (cyc == 1 + off) begin
            chk("first_req", meta_req_o, 1);
            chk("first_set", meta_set_o, 0);
            chk("first_way", meta_way_o, 0);
            chk("busy", busy_o, 1);
         end
         if (flush_ack_o) got = 1;
      end
      chk("ack_seen", got, 1);
      chk("ack_cycle", cyc, exp_ack + off);
      if (!hold) begin
         flush_i = 0;
         @(posedge clk_i); @(negedge clk_i);
         chk("ack_single", flush_ack_o, 0);
         chk("idle_busy", busy_o, 0);
      end
   endtask

   // Metadata and write-back responder; also checks every write-back and metadata write against the scoreboard.
   initial begin
      bit            rd_pend = 0, wb_pend = 0, held = 0;
      int            rd_idx = 0, wb_left = 0, idx;
      logic [TW-1:0] wb_tag_l;
      logic [1:0]    wb_set_l, h_set;
      logic          h_way, h_we, h_wv;
      exp_t          e;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            rd_pend = 0; wb_pend = 0; held = 0; stall_left = 0;
            meta_gnt_i = 0; meta_rvalid_i = 0; meta_valid_i = 0; meta_dirty_i = 0; meta_tag_i = '0;
            wb_gnt_i = 0; wb_done_i = 0;
         end else begin
            meta_rvalid_i = rd_pend;
            meta_valid_i  = rd_pend && mv[rd_idx];
            meta_dirty_i  = rd_pend && md[rd_idx];
            meta_tag_i    = rd_pend ? mt[rd_idx] : '0;
            rd_pend = 0;
            wb_done_i = 0;
            if (wb_pend) begin
               if (wb_left == 0) begin
                  wb_done_i = 1; wb_pend = 0;
                  chk("wb_tag_stable", wb_tag_o, wb_tag_l);
                  chk("wb_set_stable", wb_set_o, wb_set_l);
               end else wb_left--;
            end
            if (held && meta_req_o) begin
               chk("hold_set", meta_set_o, h_set);
               chk("hold_way", meta_way_o, h_way);
               chk("hold_we", meta_we_o, h_we);
               chk("hold_wv", meta_wvalid_o, h_wv);
            end
            meta_gnt_i = 0;
            if (meta_req_o) begin
               if (stall_left > 0) stall_left--;
               else begin
                  meta_gnt_i = 1;
                  idx = int'(meta_set_o) * NW + int'(meta_way_o);
                  if (meta_we_o) begin
                     wr_seen++;
                     chk("sb_avail_wr", sb.size() > 0, 1);
                     if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("wr_kind", e.kind, K_WR);
                        chk("wr_set", meta_set_o, e.set);
                        chk("wr_way", meta_way_o, e.way);
                        chk("wr_wvalid", meta_wvalid_o, e.wv);
                     end
                     mv[idx] = meta_wvalid_o; md[idx] = 0;
                  end else begin
                     rd_pend = 1; rd_idx = idx;
                  end
               end
            end
            held = meta_req_o && !meta_gnt_i;
            h_set = meta_set_o; h_way = meta_way_o; h_we = meta_we_o; h_wv = meta_wvalid_o;
            wb_gnt_i = wb_req_o;
            if (wb_req_o) begin
               wb_seen++;
               chk("sb_avail_wb", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("wb_kind", e.kind, K_WB);
                  chk("wb_set", wb_set_o, e.set);
                  chk("wb_tag", wb_tag_o, e.tag);
               end
               wb_pend = 1; wb_left = wb_lat; wb_tag_l = wb_tag_o; wb_set_l = wb_set_o;
            end
         end
      end
   end

   initial begin
      int  cnt;
      bit  seen;
      vecs[0] = '{-1, 0, 0, '0, 0, 0, 25, 0, 0};
      vecs[1] = '{5, 1, 1, 44'h5A, 0, 0, 28, 1, 1};
      vecs[2] = '{0, 1, 0, 44'h77, 0, 0, KEEP ? 25 : 26, 0, KEEP ? 0 : 1};
      vecs[3] = '{2, 1, 1, 44'h123, 10, 5, 43, 1, 1};
      vecs[4] = '{7, 1, 1, 44'hABCDE, 2, 0, 30, 1, 1};
      vecs[5] = '{6, 1, 0, 44'h1, 0, 3, KEEP ? 28 : 29, 0, KEEP ? 0 : 1};
      wb_lat = 0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_ack", flush_ack_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_req", meta_req_o, 0);
      chk("rst_we", meta_we_o, 0);
      chk("rst_wb_req", wb_req_o, 0);
      chk("rst_wb_tag", wb_tag_o, 0);
      chk("rst_set", meta_set_o, 0);
      rst_ni = 1;
      @(negedge clk_i);

      for (int v = 0; v < 6; v++) begin
         load(vecs[v].idx, vecs[v].v, vecs[v].d, vecs[v].tag);
         build_sb();
         wb_seen = 0; wr_seen = 0; wb_lat = vecs[v].lat; stall_left = vecs[v].stall;
         run_flush(vecs[v].ack, 0, 0);
         chk("wb_count", wb_seen, vecs[v].nwb);
         chk("wr_count", wr_seen, vecs[v].nwr);
         chk("sb_drained", sb.size(), 0);
      end

      // Back-to-back fence: request stays high through the ack into the next idle cycle.
      load(-1, 0, 0, '0);
      build_sb();
      wb_seen = 0; wr_seen = 0; wb_lat = 0;
      run_flush(25, 0, 1);
      run_flush(25, 1, 0);
      chk("b2b_wr_count", wr_seen, 0);

      // Reset while a write-back is outstanding.
      load(1, 1, 1, 44'h3C);
      build_sb();
      wb_seen = 0; wr_seen = 0; wb_lat = 10;
      flush_i = 1;
      seen = 0; cnt = 0;
      while (!seen && cnt < 200) begin
         @(negedge clk_i); cnt++;
         seen = wb_req_o;
      end
      chk("rst_wb_reached", seen, 1);
      @(posedge clk_i); @(negedge clk_i);
      chk("in_wait_wb_busy", busy_o, 1);
      rst_ni = 0; flush_i = 0;
      @(posedge clk_i); @(negedge clk_i);
      chk("mid_rst_ack", flush_ack_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_req", meta_req_o, 0);
      chk("mid_rst_wb_req", wb_req_o, 0);
      chk("mid_rst_wb_tag", wb_tag_o, 0);
      chk("mid_rst_set", meta_set_o, 0);
      chk("mid_rst_way", meta_way_o, 0);
      chk("mid_rst_wr", wr_seen, 0);
      @(posedge clk_i); @(negedge clk_i);
      rst_ni = 1;
      @(negedge clk_i);
      build_sb();
      wb_seen = 0; wr_seen = 0; wb_lat = 10;
      run_flush(38, 0, 0);
      chk("rerun_wb_count", wb_seen, 1);
      chk("rerun_wr_count", wr_seen, 1);
      chk("rerun_sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
      $fatal(1);
   end
endmodule
